simon_cue_player: RTL and testbench
===================================

Name: simon_cue_player

Overview:
- Output-side counterpart to the push-button input path of the Simon game.
- Accepts a one-cycle colour request from the game FSM through a valid/ready handshake.
- Presents that colour to the player as a timed, clean one-hot LED level plus a per-colour square-wave tone, followed by a silent gap.
- Signals completion so the FSM can issue the next cue in the sequence.

Parameters:
- CW, 26: width of the on/gap duration counter.
- ON_CYCLES, 40_000_000: cycles LED and tone are active (400 ms at 100 MHz); legal range ≥2.
- GAP_CYCLES, 10_000_000: dark/silent cycles after each cue (100 ms); legal range ≥1.
- TW, 18: width of the tone half-period counter.
- HALF0, 151686: tone half-period in cycles for colour 0 (≈329.6 Hz).
- HALF1, 191113: tone half-period in cycles for colour 1 (≈261.6 Hz).
- HALF2, 227273: tone half-period in cycles for colour 2 (220 Hz).
- HALF3, 113636: tone half-period in cycles for colour 3 (440 Hz).
- All HALFn must be ≥1.

Ports:
- clk  in  1  system clock, 100 MHz; single clock domain.
- rst_n  in  1  reset, asynchronous and active-low.
- req_valid  in  1  cue request from the game FSM.
- req_color  in  2  colour index; sampled only on acceptance.
- req_ready  out  1  block idle and able to accept a request.
- abort  in  1  synchronous cancel of the current cue.
- led  out  4  one-hot colour LED drive.
- tone  out  1  square wave to the buzzer.
- busy  out  1  high while in ON or GAP.
- done  out  1  one-cycle pulse when a cue completes normally.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0, asynchronous):
  - state=IDLE; led=0, tone=0, busy=0, done=0, req_ready=1.
  - Duration counter, tone counter and latched colour all cleared.
- States: IDLE, ON, GAP.
- Acceptance occurs at an edge where req_valid=1, req_ready=1 and abort=0.
  - req_color is latched.
  - Next state is ON; led=1<<req_color, busy=1, req_ready=0.
  - Duration counter and tone counter are cleared; tone=0.
- ON:
  - led is held for exactly ON_CYCLES cycles, counted from the first cycle after the accepting edge.
  - Tone counter increments each cycle. When it equals HALFsel-1, tone toggles and the counter returns to 0.
  - First rising edge of tone appears HALFsel cycles into ON.
  - On the last ON cycle: next state is GAP; led=0, tone=0, duration counter cleared.
- GAP:
  - led=0, tone=0, busy=1 for exactly GAP_CYCLES cycles.
  - On the last GAP cycle: next state is IDLE; done=1 for one cycle, busy=0, req_ready=1.
- IDLE:
  - led=0, tone=0, busy=0, req_ready=1.
  - done is high only in the first IDLE cycle after GAP.
  - A request may be accepted during the done cycle (back-to-back cues).
- abort=1 sampled in ON or GAP:
  - Next state is IDLE; led=0, tone=0, busy=0, req_ready=1; counters cleared.
  - done is not pulsed.
- abort=1 in IDLE: no acceptance even if req_valid=1. abort overrides a simultaneous valid request.
- Requests presented while busy are ignored. No queueing; the requester must hold req_valid until req_ready.
- req_color changes after acceptance have no effect on the active cue.
- Asynchronous reset mid-cue: everything returns to reset values immediately; no done pulse.
- Counters never wrap in legal configurations. CW must be ≥ clog2(max(ON_CYCLES, GAP_CYCLES)); TW must be ≥ clog2(max HALFn).

Test Plan:
- Bench parameters: ON_CYCLES=8, GAP_CYCLES=4, HALF0=2, HALF1=3, HALF2=1, HALF3=4.
- Reset then idle: after rst_n deasserts -> req_ready=1, led=0000, tone=0, busy=0, done=0.
- Request colour 1 at edge T:
  - led=0010 for cycles T+1..T+8.
  - tone toggles at T+4 and T+7 (high T+4..T+6, low from T+7).
  - GAP T+9..T+12.
  - done=1 and req_ready=1 at T+13.
- Back-to-back: colour 0 then colour 3 with req_valid held high -> second acceptance in the done cycle. led=1000 starts the cycle after done, with no extra idle cycle.
- Colour 2 (HALF=1) -> tone toggles every cycle during ON, i.e. 8 ON cycles give 0,1,0,1,... and tone=0 in GAP.
- Abort at the 3rd ON cycle -> next cycle led=0, busy=0, req_ready=1, no done. A new request is then accepted normally.
- Abort with simultaneous req_valid in IDLE -> no acceptance, led stays 0. rst_n pulled low mid-GAP -> all outputs return to reset values immediately, no done.

Source files
------------

// File: rtl/simon_cue_player.sv
// simon_cue_player: plays one Simon colour cue as a timed one-hot LED plus a
// per-colour square-wave tone, then a silent gap, and pulses done on completion.
`default_nettype none

module simon_cue_player #(
    parameter int CW         = 26,
    parameter int ON_CYCLES  = 40_000_000,
    parameter int GAP_CYCLES = 10_000_000,
    parameter int TW         = 18,
    parameter int HALF0      = 151686,
    parameter int HALF1      = 191113,
    parameter int HALF2      = 227273,
    parameter int HALF3      = 113636
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [1:0] req_color,
    output logic       req_ready,
    input  logic       abort,
    output logic [3:0] led,
    output logic       tone,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

    state_t          state;
    logic [CW-1:0]   dur;
    logic [TW-1:0]   tcnt;
    logic [1:0]      color;
    logic [TW-1:0]   half_last;

    always_comb begin
        half_last = TW'(HALF0 - 1);
        case (color)
            2'd0:    half_last = TW'(HALF0 - 1);
            2'd1:    half_last = TW'(HALF1 - 1);
            2'd2:    half_last = TW'(HALF2 - 1);
            default: half_last = TW'(HALF3 - 1);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            dur       <= '0;
            tcnt      <= '0;
            color     <= 2'd0;
            led       <= 4'b0000;
            tone      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // abort takes priority over a simultaneous request
                    if (req_valid && !abort) begin
                        state     <= S_ON;
                        color     <= req_color;
                        led       <= 4'b0001 << req_color;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                        dur       <= '0;
                        tcnt      <= '0;
                        tone      <= 1'b0;
                    end
                end
                S_ON: begin
                    if (abort) begin
                        state     <= S_IDLE;
                        led       <= 4'b0000;
                        tone      <= 1'b0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        dur       <= '0;
                        tcnt      <= '0;
                    end else if (dur == ON_LAST) begin
                        state <= S_GAP;
                        led   <= 4'b0000;
                        tone  <= 1'b0;
                        dur   <= '0;
                        tcnt  <= '0;
                    end else begin
                        dur <= dur + 1'b1;
                        if (tcnt == half_last) begin
                            tone <= ~tone;
                            tcnt <= '0;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (abort) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        dur       <= '0;
                    end else if (dur == GAP_LAST) begin
                        state     <= S_IDLE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        dur       <= '0;
                    end else begin
                        dur <= dur + 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    led       <= 4'b0000;
                    tone      <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    dur       <= '0;
                    tcnt      <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_simon_cue_player.sv
// Scoreboard bench for simon_cue_player: a cue-position reference model predicts
// every cycle's outputs; a monitor compares them one cycle-sample at a time.
`default_nettype none

module tb_simon_cue_player;

    localparam int ON  = 8;
    localparam int GAP = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [1:0] req_color;
    logic       req_ready;
    logic       abort;
    logic [3:0] led;
    logic       tone;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    int half [4] = '{2, 3, 1, 4};

    // {req_ready, done, busy, tone, led}
    logic [7:0] exp_q [$];

    simon_cue_player #(
        .CW(26), .ON_CYCLES(ON), .GAP_CYCLES(GAP), .TW(18),
        .HALF0(2), .HALF1(3), .HALF2(1), .HALF3(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_color(req_color),
        .req_ready(req_ready), .abort(abort), .led(led), .tone(tone),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference model: a cue is just "k cycles since acceptance"; outputs follow
    // directly from where k falls in the ON window, GAP window or beyond.
    bit m_active = 1'b0;
    int m_k      = 0;
    int m_col    = 0;

    always @(posedge clk) begin
        logic [7:0] e;
        bit         fin;
        fin = 1'b0;
        if (!rst_n) begin
            m_active = 1'b0;
            m_k      = 0;
        end else if (!m_active) begin
            if (req_valid && !abort) begin
                m_active = 1'b1;
                m_k      = 1;
                m_col    = int'(req_color);
            end
        end else if (abort) begin
            m_active = 1'b0;
        end else begin
            m_k = m_k + 1;
            if (m_k > ON + GAP) begin
                m_active = 1'b0;
                fin      = 1'b1;
            end
        end
        if (m_active) begin
            e = 8'b0010_0000;
            if (m_k <= ON) begin
                e[3:0] = 4'(1 << m_col);
                e[4]   = (((m_k - 1) / half[m_col]) % 2) == 1;
            end
        end else begin
            e    = 8'b1000_0000;
            e[6] = fin;
        end
        exp_q.push_back(e);
    end

    always @(posedge clk) begin
        logic [7:0] e;
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty t=%0t", $time);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if ({req_ready, done, busy, tone, led} !== e) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t got ready=%b done=%b busy=%b tone=%b led=%b expected ready=%b done=%b busy=%b tone=%b led=%b",
                         $time, req_ready, done, busy, tone, led, e[7], e[6], e[5], e[4], e[3:0]);
            end
        end
    end

    // Present a request and hold it until the handshake completes; caller is at a negedge.
    task automatic send(input logic [1:0] c);
        bit ok;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_color = c;
        for (int i = 0; i < 100; i++) begin
            if (req_ready && !abort) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        req_color = 2'($urandom);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout colour=%0d ready=%b expected ready=1", c, req_ready);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_color = 2'd0;
        abort     = 1'b0;
        idle_cycles(3);
        rst_n = 1'b1;
        idle_cycles(3);

        // Single cue, colour 1: LED, tone timing, gap and done pulse
        send(2'd1);
        idle_cycles(ON + GAP + 3);

        // Back-to-back: second request held high and taken in the done cycle
        send(2'd0);
        send(2'd3);
        idle_cycles(ON + GAP + 3);

        // HALF=1 colour toggles every ON cycle
        send(2'd2);
        idle_cycles(ON + GAP + 3);

        // Abort in the third ON cycle, then a normal cue
        send(2'd1);
        idle_cycles(2);
        abort = 1'b1;
        idle_cycles(1);
        abort = 1'b0;
        idle_cycles(2);
        send(2'd3);
        idle_cycles(ON + GAP + 3);

        // Abort overrides a valid request in IDLE
        req_valid = 1'b1;
        req_color = 2'd2;
        abort     = 1'b1;
        idle_cycles(3);
        req_valid = 1'b0;
        abort     = 1'b0;
        idle_cycles(2);

        // Asynchronous reset in the middle of GAP
        send(2'd0);
        idle_cycles(ON + 1);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, done, busy, tone, led} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL async_reset got ready=%b done=%b busy=%b tone=%b led=%b expected ready=1 done=0 busy=0 tone=0 led=0000",
                     req_ready, done, busy, tone, led);
        end
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(2);

        // Randomized traffic, including requests while busy and sporadic aborts
        for (int i = 0; i < 600; i++) begin
            req_valid = 1'($urandom);
            req_color = 2'($urandom);
            abort     = ($urandom_range(0, 19) == 0);
            idle_cycles(1);
        end
        req_valid = 1'b0;
        abort     = 1'b0;
        idle_cycles(ON + GAP + 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
